// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: stage-buffer state encoding, per-stage control widths
// and the packed control payloads carried between stages.
package pipeline_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    localparam int unsigned EXEC_CTRL_W = 16;
    localparam int unsigned MEM_CTRL_W  = 8;
    localparam int unsigned WB_CTRL_W   = 4;

    typedef struct packed {
        logic       regwrite;
        logic [2:0] resultsrc;
        logic       memwrite;
        logic       jump;
        logic       branch;
        logic [3:0] alucontrol;
        logic       alusrc;
        logic       jalr;
        logic [2:0] funct3;
    } exec_ctrl_t;

    typedef struct packed {
        logic       regwrite;
        logic [2:0] resultsrc;
        logic       memwrite;
        logic [2:0] funct3;
    } mem_ctrl_t;

    typedef struct packed {
        logic       regwrite;
        logic [2:0] resultsrc;
    } wb_ctrl_t;

endpackage

// File: rtl/pipe_slot.sv
// One payload register (control + data) with independent clears for the control
// and data fields; clears take priority over load.
module pipe_slot #(
    parameter int unsigned CTRL_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 175
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  clear_ctrl,
    input  logic                  clear_data,
    input  logic [CTRL_WIDTH-1:0] d_ctrl,
    input  logic [DATA_WIDTH-1:0] d_data,
    output logic [CTRL_WIDTH-1:0] q_ctrl,
    output logic [DATA_WIDTH-1:0] q_data
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_ctrl <= '0;
            q_data <= '0;
        end else begin
            if (clear_ctrl) begin
                q_ctrl <= '0;
            end else if (load) begin
                q_ctrl <= d_ctrl;
            end
            if (clear_data) begin
                q_data <= '0;
            end else if (load) begin
                q_data <= d_data;
            end
        end
    end

endmodule

// File: rtl/pipeline_stage_buf.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer and
// bubble-inserting flush; out_ctrl reads as NOP whenever no entry is presented.
module pipeline_stage_buf
    import pipeline_pkg::*;
#(
    parameter int unsigned CTRL_WIDTH         = 16,
    parameter int unsigned DATA_WIDTH         = 175,
    parameter int unsigned SKID               = 1,
    parameter int unsigned ZERO_DATA_ON_FLUSH = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occupancy
);

    localparam logic [1:0] ST_EMPTY = EMPTY;
    localparam logic [1:0] ST_ONE   = ONE;
    localparam logic [1:0] ST_FULL  = FULL;

    logic [1:0]            state;
    logic [1:0]            state_nx;
    logic                  valid_q;
    logic                  in_fire;
    logic                  out_fire;
    logic                  main_load;
    logic                  main_from_skid;
    logic                  main_clr_ctrl;
    logic                  skid_load;
    logic                  skid_clr_ctrl;
    logic                  clr_data;
    logic [CTRL_WIDTH-1:0] main_d_ctrl;
    logic [DATA_WIDTH-1:0] main_d_data;
    logic [CTRL_WIDTH-1:0] skid_ctrl;
    logic [DATA_WIDTH-1:0] skid_data;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = valid_q & out_ready;
    assign out_valid = valid_q;
    assign occupancy = state;

    // Next-state and slot control; flush overrides every handshake event.
    always_comb begin
        state_nx       = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clr_ctrl  = 1'b0;
        skid_load      = 1'b0;
        skid_clr_ctrl  = 1'b0;
        clr_data       = 1'b0;
        if (flush) begin
            state_nx      = ST_EMPTY;
            main_clr_ctrl = 1'b1;
            skid_clr_ctrl = 1'b1;
            clr_data      = (ZERO_DATA_ON_FLUSH != 0);
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_nx  = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire && (SKID != 0)) begin
                        state_nx  = ST_FULL;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_nx      = ST_EMPTY;
                        main_clr_ctrl = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_nx       = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr_ctrl  = 1'b1;
                    end
                end
                default: state_nx = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_EMPTY;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nx;
            valid_q <= (state_nx != ST_EMPTY);
        end
    end

    assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_d_data = main_from_skid ? skid_data : in_data;

    pipe_slot #(
        .CTRL_WIDTH (CTRL_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_main (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (main_load),
        .clear_ctrl (main_clr_ctrl),
        .clear_data (clr_data),
        .d_ctrl     (main_d_ctrl),
        .d_data     (main_d_data),
        .q_ctrl     (out_ctrl),
        .q_data     (out_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic ready_q;

            // Registered ready removes any out_ready -> in_ready combinational path.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= (state_nx != ST_FULL);
                end
            end

            assign in_ready = rst_n & ~flush & ready_q;

            pipe_slot #(
                .CTRL_WIDTH (CTRL_WIDTH),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_skid (
                .clk        (clk),
                .rst_n      (rst_n),
                .load       (skid_load),
                .clear_ctrl (skid_clr_ctrl),
                .clear_data (clr_data),
                .d_ctrl     (in_ctrl),
                .d_data     (in_data),
                .q_ctrl     (skid_ctrl),
                .q_data     (skid_data)
            );
        end else begin : g_noskid
            assign in_ready  = rst_n & ~flush & (~valid_q | out_ready);
            assign skid_ctrl = '0;
            assign skid_data = '0;
        end
    endgenerate

endmodule

// File: tb/tb_pipeline_stage_buf.sv
// Bench for pipeline_stage_buf: three instances (skid, no-skid, skid with data-zeroing
// flush) share stimulus and are each checked against a queue model every cycle.
module tb_pipeline_stage_buf;

    localparam int unsigned CW = 16;
    localparam int unsigned DW = 175;
    localparam int unsigned EW = CW + DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b1;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = 16'hFFFF;
    logic [DW-1:0] in_data = '0;

    logic [2:0]    rdy;
    logic [2:0]    ov;
    logic [CW-1:0] oc  [3];
    logic [DW-1:0] od  [3];
    logic [1:0]    occ [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_stage_buf #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .SKID(1), .ZERO_DATA_ON_FLUSH(0)) dut_skid (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
        .out_ctrl(oc[0]), .out_data(od[0]), .occupancy(occ[0]));

    pipeline_stage_buf #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .SKID(0), .ZERO_DATA_ON_FLUSH(0)) dut_noskid (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
        .out_ctrl(oc[1]), .out_data(od[1]), .occupancy(occ[1]));

    pipeline_stage_buf #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .SKID(1), .ZERO_DATA_ON_FLUSH(1)) dut_zero (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready),
        .out_ctrl(oc[2]), .out_data(od[2]), .occupancy(occ[2]));

    // Model: an ordered list of held entries per instance plus the last data word shown.
    logic [EW-1:0] ent  [3][3];
    int            cnt  [3];
    logic [DW-1:0] held [3];

    function automatic bit has_skid(input int i);
        return i != 1;
    endfunction

    function automatic bit zero_on_flush(input int i);
        return i == 2;
    endfunction

    function automatic logic exp_ready(input int i);
        if (!rst_n || flush) return 1'b0;
        if (has_skid(i)) return cnt[i] < 2;
        return (cnt[i] == 0) || out_ready;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin
            cnt[i]  = 0;
            held[i] = '0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic inf;
            logic outf;
            inf  = in_valid && exp_ready(i);
            outf = (cnt[i] != 0) && out_ready;
            if (!rst_n) begin
                cnt[i]  = 0;
                held[i] = '0;
            end else if (flush) begin
                cnt[i] = 0;
                if (zero_on_flush(i)) held[i] = '0;
            end else begin
                if (outf) begin
                    ent[i][0] = ent[i][1];
                    ent[i][1] = ent[i][2];
                    cnt[i]    = cnt[i] - 1;
                end
                if (inf) begin
                    ent[i][cnt[i]] = {in_ctrl, in_data};
                    cnt[i]         = cnt[i] + 1;
                end
                if (cnt[i] > 0) held[i] = ent[i][0][DW-1:0];
            end
        end
    end

    task automatic chk(input string name, input int i, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d] @%0t: got %h expected %h", name, i, $time, act, exp);
        end
    endtask

    // Every cycle: all outputs of all instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [CW-1:0] ec;
            ec = (cnt[i] != 0) ? ent[i][0][EW-1:DW] : '0;
            chk("out_valid", i, EW'(ov[i]), EW'(cnt[i] != 0));
            chk("out_ctrl", i, EW'(oc[i]), EW'(ec));
            chk("out_data", i, EW'(od[i]), EW'(held[i]));
            chk("occupancy", i, EW'(occ[i]), EW'(cnt[i]));
            chk("in_ready", i, EW'(rdy[i]), EW'(exp_ready(i)));
        end
    end

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic f, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = rand_data();
        flush     = f;
        out_ready = r;
    endtask

    logic [DW-1:0] d44;
    logic [2:0]    pat;

    initial begin
        // Reset held with a live, all-ones input that must be ignored.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 0, EW'(ov[0]), EW'(1'b0));
        chk("rst_ctrl", 0, EW'(oc[0]), EW'(16'h0));
        chk("rst_data", 0, EW'(od[0]), EW'(0));
        chk("rst_occ", 0, EW'(occ[0]), EW'(2'd0));
        chk("rst_ready", 0, EW'(rdy[0]), EW'(1'b0));
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 0, EW'(rdy[0]), EW'(1'b1));
        chk("post_rst_ready", 1, EW'(rdy[1]), EW'(1'b1));

        // Back-to-back streaming 1..8.
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, CW'(k), 1'b0, 1'b1);
            @(negedge clk);
            if (k > 1) begin
                chk("stream_ctrl", 0, EW'(oc[0]), EW'(k - 1));
                chk("stream_occ", 0, EW'(occ[0]), EW'(2'd1));
            end
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("stream_last", 0, EW'(oc[0]), EW'(16'd8));
        drive(1'b0, '0, 1'b0, 1'b1);

        // Back-pressure fills the skid, then drains in order.
        drive(1'b1, 16'h11, 1'b0, 1'b0);
        drive(1'b1, 16'h22, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_occ", 0, EW'(occ[0]), EW'(2'd2));
        chk("bp_ready", 0, EW'(rdy[0]), EW'(1'b0));
        chk("bp_ctrl", 0, EW'(oc[0]), EW'(16'h11));
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("drain_a", 0, EW'(oc[0]), EW'(16'h11));
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("drain_b", 0, EW'(oc[0]), EW'(16'h22));
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("drain_occ", 0, EW'(occ[0]), EW'(2'd0));

        // Flush while full with a new entry offered.
        drive(1'b1, 16'h44, 1'b0, 1'b0);
        d44 = in_data;
        drive(1'b1, 16'h55, 1'b0, 1'b0);
        drive(1'b1, 16'h33, 1'b1, 1'b0);
        @(negedge clk);
        chk("pre_flush_occ", 0, EW'(occ[0]), EW'(2'd2));
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("flush_valid", 0, EW'(ov[0]), EW'(1'b0));
        chk("flush_ctrl", 0, EW'(oc[0]), EW'(16'h0));
        chk("flush_occ", 0, EW'(occ[0]), EW'(2'd0));
        chk("flush_hold_data", 0, EW'(od[0]), EW'(d44));
        chk("flush_zero_data", 2, EW'(od[2]), EW'(0));
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            @(negedge clk);
            chk("no_0x33", 0, EW'(ov[0]), EW'(1'b0));
        end

        // No-skid: in_ready follows out_ready within the cycle.
        drive(1'b1, 16'h61, 1'b0, 1'b0);
        pat = 3'b101;
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, CW'(16'h62 + j), 1'b0, pat[j]);
            @(negedge clk);
            chk("noskid_ready", 1, EW'(rdy[1]), EW'(pat[j]));
        end
        repeat (4) drive(1'b0, '0, 1'b0, 1'b1);

        // Random traffic with occasional flush.
        for (int n = 0; n < 10000; n++) begin
            drive(1'($urandom_range(0, 99) < 60), CW'($urandom()),
                  1'($urandom_range(0, 99) < 5), 1'($urandom_range(0, 99) < 60));
        end

        // Reset in the middle of traffic discards everything.
        drive(1'b1, 16'h77, 1'b0, 1'b0);
        drive(1'b1, 16'h78, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_occ", 0, EW'(occ[0]), EW'(2'd0));
        chk("mid_rst_data", 0, EW'(od[0]), EW'(0));
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_buf.md
# pipeline_stage_buf

Parametrised pipeline stage register, successor to the fixed-field decode-to-execute register. It carries one control field and one data field between any two pipeline stages using a valid/ready handshake, optional 2-entry skid buffering, and a flush that inserts a bubble. All stages (F/D, D/E, E/M, M/W) instantiate it, so back-pressure from a multi-cycle unit no longer requires a global stall net.

## Interface
- CTRL_WIDTH, 16: control payload bits. Zero means NOP.
- DATA_WIDTH, 175: data payload bits.
- SKID, 1: 1 gives a 2-entry skid buffer with registered in_ready; 0 gives a single entry with combinational in_ready.
- ZERO_DATA_ON_FLUSH, 0: 1 means flush also clears held data; 0 means data is held.

Ports:
- clk  in  1  clock; all state updates on posedge. One clock, reset synchronous, active-low.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  kill all held entries on this edge.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_WIDTH  upstream control.
- in_data  in  DATA_WIDTH  upstream data.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_WIDTH  control; 0 whenever out_valid=0.
- out_data  out  DATA_WIDTH  data.
- occupancy  out  2  held entries, 0..2 (0..1 if SKID=0).

## Operation
- Transfers: an input fire is in_valid&in_ready. An output fire is out_valid&out_ready.
- State is EMPTY, ONE or FULL. FULL exists only when SKID=1.
- The main slot drives out_*. The skid slot holds the overflow entry.
- EMPTY:
  - input fire → ONE, main loads in_*.
- ONE:
  - input and output fire together → stay in ONE, main loads in_*.
  - input fire only → FULL (SKID=1), skid loads in_*.
  - output fire only → EMPTY.
- FULL:
  - output fire → ONE, main loads skid.
  - in_ready=0 in this state.
- in_ready:
  - SKID=1: registered value of (next state ≠ FULL), ANDed with ~flush.
  - SKID=0: (~out_valid | out_ready) & ~flush.
- Bubble rule: whenever main is empty, out_ctrl=0. Draining to EMPTY clears the main control field on that edge.
- Flush has priority over every other event. On a flush edge:
  - next state is EMPTY, both slots' control fields clear, out_valid=0.
  - data clears only if ZERO_DATA_ON_FLUSH=1.
  - any concurrent in_valid is dropped. in_ready is already low during flush.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_ctrl and out_data hold stable.
  - Ordering is strict FIFO: the skid entry is never overtaken.
- occupancy equals the state encoding (EMPTY=0, ONE=1, FULL=2).

## Timing
- Latency: input fire at edge N gives out_valid=1 with that entry after edge N (1 cycle).
- Throughput: 1 entry/cycle while out_ready=1, for both SKID values.
- SKID=1: no combinational path from out_ready to in_ready. The only combinational term is flush.
- SKID=0: combinational path from out_ready to in_ready.
- Reset:
  - While rst_n=0, at each edge: state EMPTY, out_valid=0, out_ctrl=0, out_data=0, skid cleared, occupancy=0.
  - in_ready=0 combinationally while rst_n=0, and 1 on the first cycle after release.
- Reset beats flush. Reset mid-transfer discards both slots.
- Simultaneous output fire and flush: downstream has consumed the entry this cycle. Flush still empties the stage.

## Structure
- Shared package pipeline_pkg holds:
  - the stage_state_e enum (EMPTY, ONE, FULL);
  - the per-stage control width constants (EXEC_CTRL_W=16, MEM_CTRL_W, WB_CTRL_W);
  - the packed control structs for each stage (exec_ctrl_t: regwrite, resultsrc[2:0], memwrite, jump, branch, alucontrol[3:0], alusrc, jalr, funct3[2:0]).
- Sub-module pipe_slot: a CTRL+DATA register with load, clear_ctrl and clear_data inputs, instantiated twice (main and skid). The skid instance is generated only if SKID=1.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_valid=1, in_ctrl=16'hFFFF → out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=0. First cycle after release → in_ready=1.
- Streaming: SKID=1, out_ready=1, send ctrl 1..8 back-to-back → outputs 1..8 in order, one cycle behind, no gaps, occupancy=1 throughout.
- Back-pressure: send A=0x11, B=0x22 with out_ready=0 → occupancy=2, in_ready=0, out_ctrl holds 0x11. Raise out_ready → 0x11 then 0x22 on consecutive cycles, then occupancy=0.
- Flush: with occupancy=2 and in_valid=1 (ctrl 0x33), pulse flush for 1 cycle → next cycle out_valid=0, out_ctrl=0, occupancy=0, and 0x33 never appears.
  - ZERO_DATA_ON_FLUSH=0: out_data unchanged.
  - ZERO_DATA_ON_FLUSH=1: out_data=0.
- SKID=0: with out_valid=1 and out_ready toggling 1,0,1 → in_ready tracks out_ready in the same cycle, occupancy never exceeds 1, no entry lost or duplicated against a scoreboard.
- Random: 10k cycles of random in_valid, out_ready and flush (5%) for both SKID values → scoreboard order match, stable outputs under stall, out_ctrl=0 whenever out_valid=0.
